// File: rtl/mac_pipe.sv
// Multi-lane pipelined multiply-accumulate: y = c + a*b per lane, with signed/unsigned
// and wrap/saturate modes. Results are computed on entry and then delayed through STAGES slots.
module mac_pipe #(
    parameter int DATA_W = 16,
    parameter int LANES  = 1,
    parameter int STAGES = 3,
    parameter int TAG_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_a,
    input  logic [LANES*DATA_W-1:0]   in_b,
    input  logic [LANES*DATA_W-1:0]   in_c,
    input  logic                      in_signed,
    input  logic                      in_sat,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_W-1:0]   out_y,
    output logic [LANES-1:0]          out_ovf,
    output logic [TAG_W-1:0]          out_tag,
    output logic                      busy
);

    localparam int FW = 2 * DATA_W + 1;
    localparam int YW = LANES * DATA_W;

    localparam logic signed [FW-1:0] S_MAX = {{(FW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [FW-1:0] S_MIN = {{(FW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [FW-1:0] U_MAX = {{(FW-DATA_W){1'b0}}, {DATA_W{1'b1}}};

    logic              en;
    logic [YW-1:0]     y_next;
    logic [LANES-1:0]  ovf_next;

    logic [STAGES-1:0] valid_reg;
    logic [YW-1:0]     y_reg   [STAGES];
    logic [LANES-1:0]  ovf_reg [STAGES];
    logic [TAG_W-1:0]  tag_reg [STAGES];

    // The whole pipe advances together; a stalled head freezes every slot.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DATA_W-1:0]     a_l, b_l, c_l, y_l;
            logic signed [FW-1:0]  a_ext, b_ext, c_ext, full;
            logic                  too_hi, too_lo;

            assign a_l = in_a[gi*DATA_W +: DATA_W];
            assign b_l = in_b[gi*DATA_W +: DATA_W];
            assign c_l = in_c[gi*DATA_W +: DATA_W];

            always_comb begin
                a_ext  = {{(FW-DATA_W){in_signed & a_l[DATA_W-1]}}, a_l};
                b_ext  = {{(FW-DATA_W){in_signed & b_l[DATA_W-1]}}, b_l};
                c_ext  = {{(FW-DATA_W){in_signed & c_l[DATA_W-1]}}, c_l};
                // Exact at FW bits: the true sum always fits, so truncation loses nothing.
                full   = a_ext * b_ext + c_ext;
                too_hi = in_signed ? (full > S_MAX) : (full > U_MAX);
                too_lo = in_signed && (full < S_MIN);
                y_l    = full[DATA_W-1:0];
                if (in_sat && too_hi) begin
                    y_l = in_signed ? S_MAX[DATA_W-1:0] : U_MAX[DATA_W-1:0];
                end else if (in_sat && too_lo) begin
                    y_l = S_MIN[DATA_W-1:0];
                end
            end

            assign y_next[gi*DATA_W +: DATA_W] = y_l;
            assign ovf_next[gi]                = too_hi | too_lo;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
            for (int s = 0; s < STAGES; s++) begin
                y_reg[s]   <= '0;
                ovf_reg[s] <= '0;
                tag_reg[s] <= '0;
            end
        end else if (en) begin
            valid_reg[0] <= in_valid;
            y_reg[0]     <= y_next;
            ovf_reg[0]   <= ovf_next;
            tag_reg[0]   <= in_tag;
            for (int s = 1; s < STAGES; s++) begin
                valid_reg[s] <= valid_reg[s-1];
                y_reg[s]     <= y_reg[s-1];
                ovf_reg[s]   <= ovf_reg[s-1];
                tag_reg[s]   <= tag_reg[s-1];
            end
        end
    end

    assign out_valid = valid_reg[STAGES-1];
    assign out_y     = y_reg[STAGES-1];
    assign out_ovf   = ovf_reg[STAGES-1];
    assign out_tag   = tag_reg[STAGES-1];
    assign busy      = |valid_reg;

endmodule

// File: tb/tb_mac_pipe.sv
// Bench for mac_pipe: a 4-lane/3-stage instance driven with directed and random traffic,
// plus a 1-lane/1-stage instance for the single-stage corner.
module tb_mac_pipe;

    localparam int W = 8;
    localparam int L = 4;
    localparam int S = 3;
    localparam int T = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic           in_valid, in_ready, in_signed, in_sat, out_valid, out_ready, busy;
    logic [L*W-1:0] in_a, in_b, in_c, out_y;
    logic [T-1:0]   in_tag, out_tag;
    logic [L-1:0]   out_ovf;

    // Single-stage instance
    logic           b_in_valid, b_in_ready, b_in_signed, b_in_sat, b_out_valid, b_out_ready, b_busy;
    logic [W-1:0]   b_in_a, b_in_b, b_in_c, b_out_y;
    logic [T-1:0]   b_in_tag, b_out_tag;
    logic [0:0]     b_out_ovf;

    mac_pipe #(.DATA_W(W), .LANES(L), .STAGES(S), .TAG_W(T)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .in_signed(in_signed), .in_sat(in_sat), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_ovf(out_ovf), .out_tag(out_tag), .busy(busy)
    );

    mac_pipe #(.DATA_W(W), .LANES(1), .STAGES(1), .TAG_W(T)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_a(b_in_a), .in_b(b_in_b), .in_c(b_in_c),
        .in_signed(b_in_signed), .in_sat(b_in_sat), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_y(b_out_y), .out_ovf(b_out_ovf), .out_tag(b_out_tag), .busy(b_busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the mathematical values.
    function automatic logic [8:0] lane_ref(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] c, input logic sg, input logic st);
        int av, bv, cv, full, lo, hi;
        logic [7:0] y;
        av   = sg ? int'($signed(a)) : int'(a);
        bv   = sg ? int'($signed(b)) : int'(b);
        cv   = sg ? int'($signed(c)) : int'(c);
        full = av * bv + cv;
        lo   = sg ? -128 : 0;
        hi   = sg ? 127 : 255;
        y    = full[7:0];
        if (st && full > hi) y = hi[7:0];
        else if (st && full < lo) y = lo[7:0];
        return {(full < lo) || (full > hi), y};
    endfunction

    typedef struct {
        logic [L*W-1:0] y;
        logic [L-1:0]   ovf;
        logic [T-1:0]   tag;
        int             acc;
    } exp_t;

    exp_t           exp_q[$];
    int             cyc = 0;
    logic           lat_mode = 1'b0;
    logic           held = 1'b0;
    logic           acc_last = 1'b0;
    logic           popped = 1'b0;
    logic [L*W-1:0] prev_y, pop_y;
    logic [L-1:0]   prev_ovf, pop_ovf;
    logic [T-1:0]   prev_tag, pop_tag;

    // One clock of the main instance: inputs already driven; called just after a negedge.
    task automatic step();
        exp_t e;
        logic [8:0] r;
        #1;
        check("in_ready", in_ready, !(out_valid && !out_ready));
        if (held) begin
            check("hold_valid", out_valid, 1);
            check("hold_y", out_y, prev_y);
            check("hold_ovf", out_ovf, prev_ovf);
            check("hold_tag", out_tag, prev_tag);
        end
        popped = 1'b0;
        if (out_valid && out_ready) begin
            check("q_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("y", out_y, e.y);
                check("ovf", out_ovf, e.ovf);
                check("tag", out_tag, e.tag);
                if (lat_mode) check("latency", cyc - e.acc, S);
                popped  = 1'b1;
                pop_y   = out_y;
                pop_ovf = out_ovf;
                pop_tag = out_tag;
            end
        end
        acc_last = in_valid && in_ready;
        if (acc_last) begin
            for (int l = 0; l < L; l++) begin
                r = lane_ref(in_a[l*W +: W], in_b[l*W +: W], in_c[l*W +: W], in_signed, in_sat);
                e.y[l*W +: W] = r[7:0];
                e.ovf[l]      = r[8];
            end
            e.tag = in_tag;
            e.acc = cyc;
            exp_q.push_back(e);
        end
        held     = out_valid && !out_ready;
        prev_y   = out_y;
        prev_ovf = out_ovf;
        prev_tag = out_tag;
        cyc++;
        @(negedge clk);
    endtask

    task automatic rand_inputs();
        in_a      = $urandom;
        in_b      = $urandom;
        in_c      = $urandom;
        in_signed = 1'($urandom);
        in_sat    = 1'($urandom);
        in_tag    = T'($urandom);
    endtask

    // Directed single transaction on lane 0 (other lanes random), out_ready held high.
    task automatic dir(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic sg, input logic st, input logic [T-1:0] tag,
                       input logic [7:0] ey, input logic eo);
        logic seen;
        rand_inputs();
        in_a[7:0] = a;
        in_b[7:0] = b;
        in_c[7:0] = c;
        in_signed = sg;
        in_sat    = st;
        in_tag    = tag;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        lat_mode  = 1'b1;
        step();
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = popped;
        end
        check("dir_seen", seen, 1);
        if (seen) begin
            check("dir_y", pop_y[7:0], ey);
            check("dir_ovf", pop_ovf[0], eo);
            check("dir_tag", pop_tag, tag);
        end
        lat_mode = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int issued;
        logic [8:0] bexp, r;
        logic [T-1:0] btag;

        in_valid = 0; in_a = '0; in_b = '0; in_c = '0; in_signed = 0; in_sat = 0; in_tag = '0;
        out_ready = 0;
        b_in_valid = 0; b_in_a = '0; b_in_b = '0; b_in_c = '0; b_in_signed = 0; b_in_sat = 0;
        b_in_tag = '0; b_out_ready = 1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_y", out_y, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed arithmetic cases
        dir(8'd100, 8'd2,   8'd10,  1, 1, 5'd3,  8'h7F, 1);
        dir(8'd100, 8'd2,   8'd10,  1, 0, 5'd4,  8'hD2, 1);
        dir(8'h80,  8'h7F,  8'hFF,  1, 1, 5'd5,  8'h80, 1);
        dir(8'h80,  8'h80,  8'h00,  1, 1, 5'd6,  8'h7F, 1);
        dir(8'd15,  8'd15,  8'd30,  0, 1, 5'd7,  8'hFF, 0);
        dir(8'd16,  8'd16,  8'd0,   0, 1, 5'd8,  8'hFF, 1);
        dir(8'd16,  8'd16,  8'd0,   0, 0, 5'd9,  8'h00, 1);
        dir(8'hFD,  8'd5,   8'd7,   1, 0, 5'd31, 8'hF8, 0);

        // Random stream with random backpressure
        issued = 0;
        for (int i = 0; i < 600 && (issued < 40 || exp_q.size() > 0 || out_valid); i++) begin
            if (!in_valid || acc_last) begin
                if (issued < 40) begin
                    rand_inputs();
                    in_valid = 1'b1;
                    issued++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = 1'($urandom);
            step();
        end
        check("stream_drain", exp_q.size(), 0);
        check("stream_issued", issued, 40);

        // Fill, then asynchronous reset mid-stream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_inputs();
            step();
        end
        check("fill_busy", busy, 1);
        check("fill_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_y", out_y, 0);
        check("arst_out_ovf", out_ovf, 0);
        check("arst_out_tag", out_tag, 0);
        check("arst_busy", busy, 0);
        check("arst_in_ready", in_ready, 1);
        exp_q.delete();
        held = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("post_rst_idle", out_valid, 0);
            step();
        end
        dir(8'd3, 8'd4, 8'd5, 0, 0, 5'd17, 8'd17, 0);

        // Single-stage instance: result the cycle after accept, one per cycle
        for (int i = 0; i < 12; i++) begin
            b_in_a      = W'($urandom);
            b_in_b      = W'($urandom);
            b_in_c      = W'($urandom);
            b_in_signed = 1'($urandom);
            b_in_sat    = 1'($urandom);
            b_in_tag    = T'($urandom);
            b_in_valid  = 1'b1;
            #1;
            check("s1_in_ready", b_in_ready, 1);
            if (i == 0) begin
                check("s1_idle", b_out_valid, 0);
            end else begin
                check("s1_valid", b_out_valid, 1);
                check("s1_y", b_out_y, bexp[7:0]);
                check("s1_ovf", b_out_ovf, bexp[8]);
                check("s1_tag", b_out_tag, btag);
            end
            r    = lane_ref(b_in_a, b_in_b, b_in_c, b_in_signed, b_in_sat);
            bexp = r;
            btag = b_in_tag;
            @(negedge clk);
        end
        b_in_valid = 1'b0;
        #1;
        check("s1_last_valid", b_out_valid, 1);
        check("s1_last_y", b_out_y, bexp[7:0]);
        check("s1_last_tag", b_out_tag, btag);
        @(negedge clk);
        #1;
        check("s1_drained", b_out_valid, 0);
        check("s1_busy", b_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
